bcd_conv_scheduler: RTL and testbench

//  Shared, sequential double-dabble binary-to-BCD converter with a two-requester round-robin front end.
//  - Requester 0: mic Hz counter. Requester 1: a second display source (e.g. distance).
//  - One add-3/shift step per clock instead of an unrolled combinational chain.
//  - Result drives the 7-seg digit mux; done_id tells the consumer which source it belongs to.

---
 rtl/bcd_conv_scheduler_pkg.sv | 20 ++
 rtl/bcd_conv_scheduler_digit_adj.sv | 14 +
 rtl/bcd_conv_scheduler.sv | 169 ++++++++++++++++
 tb/tb_bcd_conv_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   bcd_state_t : converter FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   BCD_NIB     : bits per BCD digit
//   add3_adj    : double-dabble digit correction (>=5 ? +3)
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam int BCD_NIB = 4;

  // A digit holds at most 9 before the shift, so 9+3=12 never overflows 4 bits.
  function automatic logic [BCD_NIB-1:0] add3_adj(input logic [BCD_NIB-1:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bcd_conv_scheduler_digit_adj.sv
// bcd_digit_adj: combinational correction for one BCD digit of the
// double-dabble shift register.
//   nib_i : current digit value
//   nib_o : digit after the >=5 ? +3 adjustment
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_NIB-1:0] nib_i,
  output logic [BCD_NIB-1:0] nib_o
);

  assign nib_o = add3_adj(nib_i);

endmodule

// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: shared sequential double-dabble binary-to-BCD converter
// with a two-requester round-robin front end. One add-3/shift step per clock.
// Requester 0 is the mic Hz counter, requester 1 a second display source.
//
// Ports:
//   clk      : system clock
//   rst_n    : synchronous reset, active low
//   req      : per-requester level request, held until the matching gnt bit
//   bin0     : requester 0 operand, captured on its gnt edge
//   bin1     : requester 1 operand, captured on its gnt edge
//   gnt      : one-hot single-cycle grant pulse
//   busy     : high from the cycle after gnt through the done cycle
//   done     : single-cycle pulse; bcd_out/done_id valid from here on
//   done_id  : requester index that bcd_out belongs to
//   bcd_out  : packed BCD result, ones digit in [3:0], held until next done
//   blank    : leading-zero mask (ones digit never blanked)
//
// Build option: define BCD_BLANK_EN to generate the leading-zero mask;
// without it blank is tied to zero.
module bcd_conv_scheduler
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req,
  input  logic [BIN_W-1:0]          bin0,
  input  logic [BIN_W-1:0]          bin1,
  output logic [1:0]                gnt,
  output logic                      busy,
  output logic                      done,
  output logic                      done_id,
  output logic [BCD_NIB*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]         blank
);

  localparam int BCD_W = BCD_NIB * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  if (pow10(DIGITS) <= ((longint'(1) << BIN_W) - 1)) begin : g_range_bad
    $error("bcd_conv_scheduler: DIGITS too small for BIN_W");
  end

  bcd_state_t        state_q;
  logic [1:0]        gnt_q;
  logic              busy_q;
  logic              done_q;
  logic              done_id_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              rr_last_q;
  logic              win_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SR_W-1:0]   sreg_q;

  logic              win_d;
  logic [BCD_W-1:0]  adj_bcd;
  logic [SR_W-1:0]   step_d;
  // Bit shifted out of the top digit; always 0 for operands that fit DIGITS.
  logic              carry_unused;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (sreg_q[BIN_W + BCD_NIB*d +: BCD_NIB]),
      .nib_o (adj_bcd[BCD_NIB*d +: BCD_NIB])
    );
  end

  assign step_d       = {adj_bcd[BCD_W-2:0], sreg_q[BIN_W-1:0], 1'b0};
  assign carry_unused = adj_bcd[BCD_W-1];

  // Single requester wins outright; on a tie the one not served last wins.
  always_comb begin
    win_d = 1'b0;
    case (req)
      2'b01:   win_d = 1'b0;
      2'b10:   win_d = 1'b1;
      default: win_d = ~rr_last_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      bcd_q     <= '0;
      rr_last_q <= 1'b1;
      win_q     <= 1'b0;
      cnt_q     <= '0;
      sreg_q    <= '0;
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 1'b0;
      busy_q <= (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            gnt_q     <= win_d ? 2'b10 : 2'b01;
            win_q     <= win_d;
            rr_last_q <= win_d;
            sreg_q    <= {{BCD_W{1'b0}}, (win_d ? bin1 : bin0)};
            cnt_q     <= CNT_W'(BIN_W - 1);
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          sreg_q <= step_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= DONE;
        end
        DONE: begin
          bcd_q     <= sreg_q[SR_W-1 -: BCD_W];
          done_id_q <= win_q;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] blank_q;
  logic              zero_above;

  // Walk from the top digit down; a digit is blanked while everything above
  // it (and itself) is zero. Ones digit always shown.
  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (sreg_q[BIN_W + BCD_NIB*i +: BCD_NIB] == '0);
      blank_d[i] = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (state_q == DONE) begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
module tb_bcd_conv_scheduler;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 4;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req;
  logic [BIN_W-1:0]  bin0;
  logic [BIN_W-1:0]  bin1;
  logic [1:0]        gnt;
  logic              busy;
  logic              done;
  logic              done_id;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0] blank;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcd_conv_scheduler #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .bin0    (bin0),
    .bin1    (bin1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .bcd_out (bcd_out),
    .blank   (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by plain division.
  function automatic logic [31:0] ref_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_blank(input int v);
    logic [31:0] r;
    int p;
    r = '0;
`ifdef BCD_BLANK_EN
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      r[i] = (v < p);
      p = p * 10;
    end
`else
    p = 0;
`endif
    return r;
  endfunction

  // Waits (bounded) for a gnt at the negedge sample; returns cycle it was seen.
  task automatic wait_gnt(input string tag, output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 40);
    if (gnt == 2'b00) chk({tag, "_gnt_timeout"}, 32'(n), 32'd0);
    at = cyc;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
    if (!done) chk({tag, "_done_timeout"}, 32'(lat), 32'd0);
  endtask

  // One conversion on requester id; operand is scrambled right after gnt.
  task automatic run_conv(input int id, input int val);
    int t, lat;
    if (id == 0) bin0 = BIN_W'(val); else bin1 = BIN_W'(val);
    req[id] = 1'b1;
    wait_gnt("conv", t);
    chk("conv_gnt", 32'(gnt), (id == 0) ? 32'd1 : 32'd2);
    chk("conv_busy_at_gnt", 32'(busy), 32'd0);
    req[id] = 1'b0;
    if (id == 0) bin0 = BIN_W'($urandom); else bin1 = BIN_W'($urandom);
    wait_done("conv", lat);
    chk("conv_latency", 32'(lat), 32'(BIN_W + 1));
    chk("conv_bcd", 32'(bcd_out), ref_bcd(val));
    chk("conv_id", 32'(done_id), 32'(id));
    chk("conv_blank", 32'(blank), ref_blank(val));
    chk("conv_busy_at_done", 32'(busy), 32'd1);
  endtask

  initial begin
    int t, tprev, lat, extra_gnt, v;
    rst_n = 1'b0;
    req   = 2'b00;
    bin0  = '0;
    bin1  = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_id", 32'(done_id), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Max operand, zero operand.
    run_conv(0, 1023);
    run_conv(0, 0);
    run_conv(1, 7);

    // Requester 1 arrives mid-conversion of requester 0.
    bin0 = BIN_W'(123);
    req  = 2'b01;
    wait_gnt("mid", t);
    chk("mid_gnt0", 32'(gnt), 32'd1);
    req = 2'b00;
    repeat (3) @(negedge clk);
    bin1 = BIN_W'(456);
    req  = 2'b10;
    extra_gnt = 0;
    lat = 3;
    do begin
      @(negedge clk);
      lat++;
      if (gnt != 2'b00) extra_gnt++;
    end while (!done && lat < 40);
    chk("mid_no_gnt_while_busy", 32'(extra_gnt), 32'd0);
    chk("mid_done0_latency", 32'(lat), 32'(BIN_W + 1));
    chk("mid_bcd0", 32'(bcd_out), ref_bcd(123));
    @(negedge clk);
    chk("mid_gnt1_after_done", 32'(gnt), 32'd2);
    req = 2'b00;
    wait_done("mid1", lat);
    chk("mid_bcd1", 32'(bcd_out), ref_bcd(456));
    chk("mid_id1", 32'(done_id), 32'd1);

    // Reset five cycles into a conversion.
    bin0 = BIN_W'(999);
    req  = 2'b01;
    wait_gnt("rst", t);
    req = 2'b00;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_id", 32'(done_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_gnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) extra_gnt++;
    end
    chk("abort_no_done", 32'(extra_gnt), 32'd0);

    // Both requesting: strict alternation, 12-cycle spacing, requester 0 first.
    bin0 = BIN_W'(500);
    bin1 = BIN_W'(37);
    req  = 2'b11;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("rr", t);
      chk("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) chk("rr_spacing", 32'(t - tprev), 32'(BIN_W + 2));
      tprev = t;
      wait_done("rr", lat);
      chk("rr_bcd", 32'(bcd_out), (k % 2 == 0) ? ref_bcd(500) : ref_bcd(37));
      chk("rr_id", 32'(done_id), 32'(k % 2));
    end
    req = 2'b00;
    repeat (2) @(negedge clk);

    // Random traffic on both requesters.
    for (int k = 0; k < 40; k++) begin
      v = int'($urandom_range(0, 1023));
      run_conv(int'($urandom_range(0, 1)), v);
    end

    // Full sweep on requester 0.
    for (int k = 0; k < 1024; k++) run_conv(0, k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
